// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem address, IF/ID register
// Handles decode stall, execute redirect, end-of-memory halt and misaligned redirect halt.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 80
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        ifid_valid,
   output logic [31:0] ifid_ins,
   output logic [31:0] ifid_pc,
   output logic        halted,
   output logic        misaligned,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
   localparam logic [31:0] NOP_INS = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] ins_q;
   logic [31:0] ifpc_q;
   logic [31:0] count_q;
   logic        valid_q;
   logic        halted_q;
   logic        mis_q;
   logic [31:0] pc_d;
   logic [31:0] count_d;

   assign pc_d    = pc_q + 32'd4;
   assign count_d = count_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         ins_q    <= NOP_INS;
         ifpc_q   <= 32'h0000_0000;
         count_q  <= 32'h0000_0000;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                  pc_q     <= redirect_target;
                  valid_q  <= 1'b0;
                  mis_q    <= 1'b1;
                  halted_q <= 1'b1;
                  state_q  <= HALT;
               end else if (redirect_valid) begin
                  // wrong-path bubble; previous IF/ID contents stay visible
                  pc_q    <= redirect_target;
                  valid_q <= 1'b0;
               end else if (stall) begin
                  state_q <= RUN;
               end else if (pc_q > LAST_PC) begin
                  valid_q  <= 1'b0;
                  halted_q <= 1'b1;
                  state_q  <= HALT;
               end else begin
                  ins_q   <= imem_data;
                  ifpc_q  <= pc_q;
                  valid_q <= 1'b1;
                  pc_q    <= pc_d;
                  count_q <= count_d;
               end
            end
            HALT: valid_q <= 1'b0;
            default: begin
               valid_q  <= 1'b0;
               halted_q <= 1'b1;
               state_q  <= HALT;
            end
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign ifid_valid  = valid_q;
   assign ifid_ins    = ins_q;
   assign ifid_pc     = ifpc_q;
   assign halted      = halted_q;
   assign misaligned  = mis_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
// Directed vector table, hand sequences, and random traffic against a delivery-history model.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        ifid_valid;
   logic [31:0] ifid_ins;
   logic [31:0] ifid_pc;
   logic        halted;
   logic        misaligned;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [20];

   fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(80)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .ifid_valid(ifid_valid), .ifid_ins(ifid_ins), .ifid_pc(ifid_pc),
      .halted(halted), .misaligned(misaligned), .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd80) return mem[a[6:2]];
      return 32'hDEAD_BEEF;
   endfunction

   assign imem_data = mem_word(imem_addr);

   // Model: the IF/ID register always shows the most recently delivered pc.
   logic [31:0] m_pc;
   bit          m_boot, m_halt, m_valid, m_mis;
   logic [31:0] m_q [$];

   task automatic model_reset();
      m_pc = 32'h0; m_boot = 1; m_halt = 0; m_valid = 0; m_mis = 0;
      m_q.delete();
   endtask

   task automatic model_step(input bit st, input bit rv, input logic [31:0] rt);
      if (m_boot) m_boot = 0;
      else if (m_halt) m_valid = 0;
      else if (rv && (rt % 4 != 0)) begin
         m_pc = rt; m_valid = 0; m_mis = 1; m_halt = 1;
      end else if (rv) begin
         m_pc = rt; m_valid = 0;
      end else if (st) begin
      end else if (m_pc + 4 > 80) begin
         m_valid = 0; m_halt = 1;
      end else begin
         m_q.push_back(m_pc); m_valid = 1; m_pc = m_pc + 4;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string name);
      logic [31:0] epc, eins;
      epc  = (m_q.size() > 0) ? m_q[$] : 32'h0;
      eins = (m_q.size() > 0) ? mem_word(m_q[$]) : 32'h0000_0013;
      chk({name, ".addr"},  imem_addr, m_pc);
      chk({name, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
      chk({name, ".pc"},    ifid_pc, epc);
      chk({name, ".ins"},   ifid_ins, eins);
      chk({name, ".halt"},  {31'b0, halted}, {31'b0, m_halt});
      chk({name, ".mis"},   {31'b0, misaligned}, {31'b0, m_mis});
      chk({name, ".cnt"},   fetch_count, 32'(m_q.size()));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, ".addr"},  imem_addr, 32'h0);
      chk({name, ".valid"}, {31'b0, ifid_valid}, 32'h0);
      chk({name, ".ins"},   ifid_ins, 32'h0000_0013);
      chk({name, ".pc"},    ifid_pc, 32'h0);
      chk({name, ".halt"},  {31'b0, halted}, 32'h0);
      chk({name, ".mis"},   {31'b0, misaligned}, 32'h0);
      chk({name, ".cnt"},   fetch_count, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   typedef struct {
      logic        st;
      logic        rv;
      logic [31:0] rt;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eins;
      logic [31:0] eaddr;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tv [10];

   initial begin
      int halt_cycles;
      bit st, rv;
      logic [31:0] rt;

      for (int i = 0; i < 20; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      mem[0] = 32'h0011_5E63;
      mem[1] = 32'h00A0_0093;
      mem[2] = 32'h0140_0113;

      tv[0] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd0,  mem_word(0),  32'd4,  32'd1};
      tv[1] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  mem_word(4),  32'd8,  32'd2};
      tv[2] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4,  mem_word(4),  32'd8,  32'd2};
      tv[3] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4,  mem_word(4),  32'd8,  32'd2};
      tv[4] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4,  mem_word(4),  32'd8,  32'd2};
      tv[5] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd8,  mem_word(8),  32'd12, 32'd3};
      tv[6] = '{1'b1, 1'b1, 32'd28, 1'b0, 32'd8,  mem_word(8),  32'd28, 32'd3};
      tv[7] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd28, mem_word(28), 32'd32, 32'd4};
      tv[8] = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd28, mem_word(28), 32'd4,  32'd4};
      tv[9] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  mem_word(4),  32'd8,  32'd5};

      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      step();
      step();
      chk_reset_vals("reset");
      rst_n = 1'b1;
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1A;
      step();
      chk_reset_vals("boot");

      for (int i = 0; i < 10; i++) begin
         stall = tv[i].st; redirect_valid = tv[i].rv; redirect_target = tv[i].rt;
         step();
         chk($sformatf("vec%0d.valid", i), {31'b0, ifid_valid}, {31'b0, tv[i].ev});
         chk($sformatf("vec%0d.pc", i), ifid_pc, tv[i].epc);
         chk($sformatf("vec%0d.ins", i), ifid_ins, tv[i].eins);
         chk($sformatf("vec%0d.addr", i), imem_addr, tv[i].eaddr);
         chk($sformatf("vec%0d.cnt", i), fetch_count, tv[i].ecnt);
      end

      stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h1A;
      step();
      for (int k = 0; k < 11; k++) begin
         chk($sformatf("mis%0d.halt", k), {31'b0, halted}, 32'h1);
         chk($sformatf("mis%0d.mis", k), {31'b0, misaligned}, 32'h1);
         chk($sformatf("mis%0d.valid", k), {31'b0, ifid_valid}, 32'h0);
         chk($sformatf("mis%0d.addr", k), imem_addr, 32'h1A);
         chk($sformatf("mis%0d.pc", k), ifid_pc, 32'd4);
         chk($sformatf("mis%0d.cnt", k), fetch_count, 32'd5);
         stall = 1'($urandom); redirect_valid = 1'($urandom);
         redirect_target = 32'($urandom_range(0, 20)) * 4;
         step();
      end

      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("end%0d.pc", k), ifid_pc, 32'(4 * (k - 1)));
         chk($sformatf("end%0d.cnt", k), fetch_count, 32'(k));
      end
      chk("end.valid", {31'b0, ifid_valid}, 32'h1);
      step();
      chk("end_halt.halt", {31'b0, halted}, 32'h1);
      chk("end_halt.mis", {31'b0, misaligned}, 32'h0);
      chk("end_halt.valid", {31'b0, ifid_valid}, 32'h0);
      chk("end_halt.addr", imem_addr, 32'd80);
      chk("end_halt.cnt", fetch_count, 32'd20);

      do_reset();
      for (int k = 0; k < 10; k++) step();
      chk("mid.addr", imem_addr, 32'd40);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      step();
      rst_n = 1'b1;
      step();
      chk_reset_vals("mid_boot");
      step();
      chk("restart.valid", {31'b0, ifid_valid}, 32'h1);
      chk("restart.pc", ifid_pc, 32'h0);
      chk("restart.ins", ifid_ins, mem[0]);

      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      #1;
      model_reset();
      step();
      rst_n = 1'b1;
      halt_cycles = 0;
      for (int i = 0; i < 600; i++) begin
         if (halt_cycles > 4 || $urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            chk_model($sformatf("rnd%0d_rst", i));
            step();
            rst_n = 1'b1;
            halt_cycles = 0;
         end else begin
            st = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 10);
            rt = 32'($urandom_range(0, 24)) * 4;
            if ($urandom_range(0, 99) < 3) rt = rt | 32'($urandom_range(1, 3));
            stall = st; redirect_valid = rv; redirect_target = rt;
            step();
            model_step(st, rv, rt);
            chk_model($sformatf("rnd%0d", i));
            if (m_halt) halt_cycles++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
